// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweeper: drives every input vector into an SOP and a POS
// implementation of one function, captures both truth tables and flags disagreements.
module tt_sweep_checker #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                f_sop,
  input  logic                f_pos,
  output logic [N_IN-1:0]     vec_out,
  output logic                busy,
  output logic                done,
  output logic [(1<<N_IN)-1:0] table_sop,
  output logic [(1<<N_IN)-1:0] table_pos,
  output logic                mismatch,
  output logic [N_IN-1:0]     first_bad,
  output logic [N_IN:0]       bad_count
);

  localparam int TW = 1 << N_IN;
  localparam logic [3:0]      SETTLE_RELOAD = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST_VEC      = '1;
  localparam logic [N_IN-1:0] VEC_ONE       = N_IN'(1);
  localparam logic [N_IN:0]   BAD_ONE       = (N_IN+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAMPLE, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [TW-1:0]   table_sop_q, table_sop_d;
  logic [TW-1:0]   table_pos_q, table_pos_d;
  logic            mismatch_q, mismatch_d;
  logic [N_IN-1:0] first_bad_q, first_bad_d;
  logic [N_IN:0]   bad_count_q, bad_count_d;

  // busy/done are computed alongside the state so they come straight from flops.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vec_d       = vec_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    table_sop_d = table_sop_q;
    table_pos_d = table_pos_q;
    mismatch_d  = mismatch_q;
    first_bad_d = first_bad_q;
    bad_count_d = bad_count_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_WAIT;
          vec_d       = '0;
          cnt_d       = SETTLE_RELOAD;
          busy_d      = 1'b1;
          table_sop_d = '0;
          table_pos_d = '0;
          mismatch_d  = 1'b0;
          first_bad_d = '0;
          bad_count_d = '0;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_SAMPLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_SAMPLE: begin
        table_sop_d[vec_q] = f_sop;
        table_pos_d[vec_q] = f_pos;
        if (f_sop != f_pos) begin
          bad_count_d = bad_count_q + BAD_ONE;
          mismatch_d  = 1'b1;
          if (!mismatch_q) first_bad_d = vec_q;
        end
        if (vec_q == LAST_VEC) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          vec_d   = vec_q + VEC_ONE;
          cnt_d   = SETTLE_RELOAD;
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      vec_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      table_sop_q <= '0;
      table_pos_q <= '0;
      mismatch_q  <= 1'b0;
      first_bad_q <= '0;
      bad_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vec_q       <= vec_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      table_sop_q <= table_sop_d;
      table_pos_q <= table_pos_d;
      mismatch_q  <= mismatch_d;
      first_bad_q <= first_bad_d;
      bad_count_q <= bad_count_d;
    end
  end

  assign vec_out   = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign table_sop = table_sop_q;
  assign table_pos = table_pos_q;
  assign mismatch  = mismatch_q;
  assign first_bad = first_bad_q;
  assign bad_count = bad_count_q;

endmodule
